mux_arb_nt1: RTL

//  Parametrised N-to-1, W-bit registered multiplexer. It is the successor to the
//  4:1 5-bit combinational mux, with a valid/ready handshake on every input.
//  Two modes: explicit select (s chooses the source) or round-robin arbitration.
//  One output register stage. Sits in datapath/bus paths where several

---
 rtl/mux_arb_nt1_pkg.sv | 19 +
 rtl/mux_arb_nt1_rr_arbiter.sv | 36 +++
 rtl/mux_arb_nt1.sv | 83 ++++++++
 3 files changed

// File: rtl/mux_arb_nt1_pkg.sv
// Shared definitions for the N-to-1 registered mux/arbiter: mode encodings
// and the index-width helper used to size channel-number fields.
package mux_arb_nt1_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   // Smallest r with 2**r >= v, floored at 1 so a 2-channel mux still has
   // a one-bit index.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int k = 1; k < 31; k++) begin
         if ((1 << r) < v) r = k + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_arb_nt1_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found after ptr, wrapping from N-1 back to 0, plus the granted index.
module rr_arbiter
   import mux_arb_nt1_pkg::*;
#(
   parameter  int N  = 4,
   localparam int SW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] gidx
);

   int   idx;
   logic found;

   // Scan ptr+1 .. ptr+N (mod N); the first hit wins, so ptr itself has the
   // lowest priority.
   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            gidx       = SW'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_arb_nt1.sv
// N-to-1, W-bit registered multiplexer with valid/ready on every input.
// mode 0 takes the channel named by s; mode 1 arbitrates round-robin.
// A single output register gives one word per cycle at full throughput.
module mux_arb_nt1
   import mux_arb_nt1_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int W  = 5,
   localparam int SW = clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           mode,
   input  logic [SW-1:0]  s,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_ch,
   output logic           out_valid,
   input  logic           out_ready
);

   logic [SW-1:0] ptr;
   logic [N-1:0]  rr_grant;
   logic [SW-1:0] rr_gidx;
   logic [N-1:0]  sel_grant;
   logic [N-1:0]  grant;
   logic [SW-1:0] gidx;
   logic [W-1:0]  mux_data;
   logic          load;
   logic          xfer;

   rr_arbiter #(.N(N)) u_rr (
      .req   (in_valid),
      .ptr   (ptr),
      .en    (1'b1),
      .grant (rr_grant),
      .gidx  (rr_gidx)
   );

   // Explicit select: only the addressed channel, and only if it is valid.
   // An s value of N or more matches no channel and so grants nothing.
   always_comb begin
      sel_grant = '0;
      for (int i = 0; i < N; i++) begin
         sel_grant[i] = (s == SW'(i)) && in_valid[i];
      end
   end

   assign grant    = (mode == MODE_RR) ? rr_grant : sel_grant;
   assign gidx     = (mode == MODE_RR) ? rr_gidx : s;
   assign load     = ~out_valid | out_ready;
   assign in_ready = grant & {N{load & ~rst}};
   assign xfer     = |in_ready;

   // AND-OR data mux over the one-hot grant.
   always_comb begin
      mux_data = '0;
      for (int i = 0; i < N; i++) begin
         mux_data = mux_data | (in_data[i*W +: W] & {W{grant[i]}});
      end
   end

   // Output register and round-robin pointer; the pointer only moves on an
   // accepted round-robin transfer so it survives mode switches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= SW'(N - 1);
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= mux_data;
         out_ch    <= gidx;
         if (mode == MODE_RR) ptr <= gidx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
